// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel sink: screen defaults, address
// width, colour type and the sequencing state enum.
package pixel_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int ADDR_W       = 15;

  typedef logic [2:0] colour_t;

  // state | meaning
  // RUN   | accepting plots, writing them out as fbGrant allows
  // DRAIN | clear requested; plots refused, buffered plots flushed
  // CLEAR | writing colour 0 to every framebuffer address
  // DONE  | one-cycle clearDone pulse, then back to RUN
  typedef enum logic [1:0] {RUN, DRAIN, CLEAR, DONE} state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with a combinational head output (first-word
// fall-through), so a freshly pushed entry can be written the next cycle.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (PTR_W+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_sink.sv
// Pixel sink: buffers producer plots into a small FIFO and writes them to the
// framebuffer when granted; on request, flushes the buffer and clears the frame.
module pixel_sink
  import pixel_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              plotEn,
  input  logic [7:0]        plotX,
  input  logic [7:0]        plotY,
  input  colour_t           plotColour,
  output logic              plotReady,
  input  logic              clearReq,
  output logic              clearDone,
  input  logic              fbGrant,
  output logic              fbWe,
  output logic [ADDR_W-1:0] fbAddr,
  output colour_t           fbData,
  output logic [7:0]        dropCount
);

  localparam int ENTRY_W = ADDR_W + 3;
  localparam int CNT_W   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [7:0]          r_drop;
  logic                w_in_range;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_clr_wr;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [ADDR_W-1:0]   w_plot_addr;
  logic [ENTRY_W-1:0]  w_head;

  assign w_in_range  = (int'(plotX) < SCREEN_W) && (int'(plotY) < SCREEN_H);
  assign w_plot_addr = ADDR_W'(plotY) * ADDR_W'(SCREEN_W) + ADDR_W'(plotX);

  // Ready depends only on registered state (and reset), never on plotEn.
  assign plotReady = !resetn && (r_state == RUN) && (w_count < CNT_W'(FIFO_DEPTH));
  assign w_accept  = plotEn && plotReady;
  assign w_push    = w_accept && w_in_range && !w_full;
  assign w_pop     = !resetn && ((r_state == RUN) || (r_state == DRAIN)) && !w_empty && fbGrant;
  assign w_clr_wr  = !resetn && (r_state == CLEAR) && fbGrant;

  assign fbWe      = w_pop || w_clr_wr;
  assign fbAddr    = w_clr_wr ? r_clr_cnt : w_head[ENTRY_W-1:3];
  assign fbData    = w_clr_wr ? colour_t'(3'b000) : w_head[2:0];
  assign clearDone = !resetn && (r_state == DONE);
  assign dropCount = r_drop;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (resetn),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({w_plot_addr, plotColour}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Next-state decode for the run/drain/clear/done sequence.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (clearReq) w_state_nxt = DRAIN;
      DRAIN:   if (w_empty) w_state_nxt = CLEAR;
      CLEAR:   if (w_clr_wr && (r_clr_cnt == LAST_ADDR)) w_state_nxt = DONE;
      DONE:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // State register and clear address counter; the counter only advances on granted clear writes.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state   <= RUN;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == DRAIN)  r_clr_cnt <= '0;
      else if (w_clr_wr)     r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Saturating count of accepted plots that fell outside the frame.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_drop <= '0;
    end else if (w_accept && !w_in_range && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Bench for pixel_sink: a queue-based reference model predicts every output
// each cycle under directed and random stimulus.
module tb_pixel_sink;
  import pixel_pkg::*;

  localparam int W = 160;
  localparam int H = 120;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        resetn, plotEn, clearReq, fbGrant;
  logic [7:0]  plotX, plotY;
  logic [2:0]  plotColour;
  logic        plotReady, clearDone, fbWe;
  logic [14:0] fbAddr;
  logic [2:0]  fbData;
  logic [7:0]  dropCount;

  int total = 0;
  int bad   = 0;

  // reference model: pending plots as addr*8+colour, plus the clear phase flags
  int q[$];
  bit m_drain, m_clear, m_done;
  int m_clr, m_drop;

  logic        s_ready, s_we, s_done;
  logic [14:0] s_addr;
  logic [2:0]  s_data;
  logic [7:0]  s_drop;

  always #5 clk = ~clk;

  pixel_sink dut (
    .clk(clk), .resetn(resetn), .plotEn(plotEn), .plotX(plotX), .plotY(plotY),
    .plotColour(plotColour), .plotReady(plotReady), .clearReq(clearReq),
    .clearDone(clearDone), .fbGrant(fbGrant), .fbWe(fbWe), .fbAddr(fbAddr),
    .fbData(fbData), .dropCount(dropCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic step();
    bit run, ready, popq, we, done;
    int ea, ed;
    @(negedge clk);
    run   = !(m_drain || m_clear || m_done);
    ready = !resetn && run && (q.size() < D);
    popq  = !resetn && (run || m_drain) && (q.size() > 0) && fbGrant;
    we    = popq || (!resetn && m_clear && fbGrant);
    ea    = popq ? q[0] / 8 : m_clr;
    ed    = popq ? q[0] % 8 : 0;
    done  = !resetn && m_done;
    s_ready = plotReady; s_we = fbWe; s_addr = fbAddr; s_data = fbData;
    s_done  = clearDone; s_drop = dropCount;
    chk("ready", plotReady, ready);
    chk("we", fbWe, we);
    if (we) begin
      chk("addr", fbAddr, ea);
      chk("data", fbData, ed);
    end
    chk("done", clearDone, done);
    chk("drop", dropCount, m_drop);
    @(posedge clk);
    if (resetn) begin
      q.delete();
      m_drain = 0; m_clear = 0; m_done = 0; m_clr = 0; m_drop = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_clear) begin
      if (fbGrant) begin
        if (m_clr == W * H - 1) begin m_clear = 0; m_done = 1; end
        else m_clr++;
      end
    end else if (m_drain) begin
      if (q.size() == 0) begin m_drain = 0; m_clear = 1; m_clr = 0; end
      else if (popq) void'(q.pop_front());
    end else begin
      if (popq) void'(q.pop_front());
      if (plotEn && ready) begin
        if (plotX < W && plotY < H) q.push_back((plotY * W + plotX) * 8 + plotColour);
        else if (m_drop < 255) m_drop++;
      end
      if (clearReq) m_drain = 1;
    end
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    plotEn = 1; plotX = 8'(x); plotY = 8'(y); plotColour = 3'(c);
  endtask

  initial begin
    int nw, nd;
    int wa[3];
    bit reached;
    resetn = 1; plotEn = 0; clearReq = 0; fbGrant = 0;
    plotX = 0; plotY = 0; plotColour = 0;
    @(posedge clk); #1;
    step();
    chk("rst_ready", s_ready, 0);
    chk("rst_drop", s_drop, 0);
    resetn = 0;

    // single plot, minimum latency
    fbGrant = 1; plot(27, 10, 5);
    step();
    chk("rdy_after_rst", s_ready, 1);
    plotEn = 0;
    step();
    chk("lat_we", s_we, 1);
    chk("lat_addr", s_addr, 1627);
    chk("lat_data", s_data, 5);

    // fill with grant stalled, then drain in order
    fbGrant = 0;
    for (int i = 0; i < 5; i++) begin
      plot($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7));
      step();
    end
    chk("full_ready", s_ready, 0);
    plotEn = 0; fbGrant = 1;
    for (int i = 0; i < 4; i++) step();
    step();
    chk("drained_ready", s_ready, 1);
    chk("drained_we", s_we, 0);

    // out-of-range plots and drop saturation
    plot(160, 0, 1); step();
    plot(0, 120, 2); step();
    plotEn = 0; step();
    chk("drop2", s_drop, 2);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) plot($urandom_range(W, 255), $urandom_range(0, 255), $urandom_range(0, 7));
      else            plot($urandom_range(0, 255), $urandom_range(H, 255), $urandom_range(0, 7));
      step();
    end
    plotEn = 0; step();
    chk("drop_sat", s_drop, 255);

    // random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      resetn = ($urandom_range(0, 399) == 0);
      plotEn = ($urandom_range(0, 3) != 0);
      plotX = 8'($urandom_range(0, 179));
      plotY = 8'($urandom_range(0, 139));
      plotColour = 3'($urandom);
      fbGrant = ($urandom_range(0, 9) < 6);
      step();
    end
    resetn = 1; plotEn = 0; step();
    resetn = 0;

    // full clear with two buffered plots; clearReq coincides with the second plot
    fbGrant = 0;
    plot(5, 7, 3); step();
    plot(159, 119, 6); clearReq = 1; step();
    plotEn = 0; clearReq = 0; step();
    chk("drain_ready", s_ready, 0);
    fbGrant = 1; nw = 0; nd = 0;
    for (int i = 0; i < 19400 && nd == 0; i++) begin
      step();
      if (s_we) begin
        if (nw < 3) wa[nw] = s_addr;
        nw++;
      end
      if (s_done) nd++;
    end
    chk("clr_done", nd, 1);
    chk("clr_writes", nw, 19202);
    chk("first_plot", wa[0], 1125);
    chk("second_plot", wa[1], 19199);
    chk("clr_first_addr", wa[2], 0);
    step();
    chk("run_again", s_ready, 1);
    chk("done_once", s_done, 0);

    // reset in the middle of a clear with a stuttering grant
    for (int i = 0; i < 3; i++) begin
      plot($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7));
      fbGrant = 0; step();
    end
    plotEn = 0; clearReq = 1; step();
    clearReq = 0; reached = 0;
    for (int i = 0; i < 20000 && !reached; i++) begin
      fbGrant = ($urandom_range(0, 3) != 0);
      clearReq = ($urandom_range(0, 49) == 0);
      if (m_clear && m_clr == 5000) reached = 1;
      else step();
    end
    chk("reach5000", reached, 1);
    clearReq = 0; fbGrant = 1; resetn = 1;
    step();
    chk("rst_mid_we", s_we, 0);
    chk("rst_mid_done", s_done, 0);
    resetn = 0;
    step();
    chk("post_rst_ready", s_ready, 1);
    chk("post_rst_drop", s_drop, 0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_done) nd++;
    end
    chk("no_done_after_rst", nd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 Parameter SCREEN_W, default 160, frame width in pixels.
REQ-002 Parameter SCREEN_H, default 120, frame height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4, entries in the plot buffer (power of two).
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 resetn  in  1  synchronous, active-high reset (asserted = 1, despite the name).
REQ-006 plotEn  in  1  producer request: plotX/plotY/plotColour valid this cycle.
REQ-007 plotX  in  8  pixel column.
REQ-008 plotY  in  8  pixel row.
REQ-009 plotColour  in  3  RGB colour.
REQ-010 plotReady  out  1  sink can accept; a plot transfers on plotEn & plotReady.
REQ-011 clearReq  in  1  single-cycle pulse; fill the whole frame with 3'b000.
REQ-012 clearDone  out  1  one-cycle pulse when the clear completes.
REQ-013 fbGrant  in  1  framebuffer write slot is available this cycle (scan-out has priority).
REQ-014 fbWe  out  1  framebuffer write strobe.
REQ-015 fbAddr  out  15  write address.
REQ-016 fbData  out  3  write colour.
REQ-017 dropCount  out  8  count of accepted out-of-range plots, saturating at 255.

Function
REQ-018 An accepted plot with plotX < SCREEN_W and plotY < SCREEN_H is pushed to the FIFO as {addr = plotY*SCREEN_W + plotX, colour}. Address is computed at push time in 15 bits with no truncation for the default parameters.
REQ-019 An accepted out-of-range plot is not pushed and increments dropCount; at 255, dropCount holds.
REQ-020 plotReady = 1 only in RUN with FIFO count < FIFO_DEPTH, computed from registered state with no combinational path from plotEn.
REQ-021 FIFO pop: in RUN or DRAIN, when the FIFO is non-empty and fbGrant = 1, the head entry drives fbAddr/fbData with fbWe = 1 in that same cycle, and the entry is popped.
REQ-022 Minimum latency: a plot accepted in cycle N is written in cycle N+1 (FIFO empty, fbGrant = 1 at N+1).
REQ-023 Simultaneous push and pop are legal whenever the FIFO is not full; count is unchanged. Writes remain in acceptance order.
REQ-024 fbWe = 0 whenever fbGrant = 0; fbAddr/fbData are don't-care when fbWe = 0.
REQ-025 FSM states and transitions:
- RUN --clearReq--> DRAIN
- DRAIN --FIFO empty--> CLEAR, with the clear counter set to 0
- CLEAR --last address written--> DONE
- DONE --> RUN unconditionally after one cycle, with clearDone = 1 in DONE
REQ-026 In CLEAR, each cycle with fbGrant = 1 writes fbAddr = counter and fbData = 0, then the counter increments. The last address is SCREEN_W*SCREEN_H-1 (19199). With fbGrant stalled, the counter holds.
REQ-027 clearReq outside RUN is ignored. A clearReq in the same cycle as an accepted plot accepts that plot first, then enters DRAIN.

Reset
REQ-028 While resetn = 1: state = RUN, FIFO empty, clear counter = 0, dropCount = 0, fbWe = 0, clearDone = 0, and plotReady = 0 during the reset cycle.
REQ-029 Reset mid-CLEAR or mid-DRAIN abandons the operation, discards buffered plots, and emits no clearDone.
REQ-030 plotReady = 1 on the first cycle after resetn deasserts.

Structure
REQ-031 Shared package pixel_pkg holds:
- SCREEN_W/SCREEN_H defaults
- address width constant (15)
- 3-bit colour typedef
- FSM state enum {RUN, DRAIN, CLEAR, DONE}
REQ-032 The buffer is one sub-module, pixel_fifo: synchronous, parameterised depth/width, with push/pop/full/empty/count ports.

Verification
REQ-033 Reset, then plot (27,10,3'b101) with fbGrant = 1: the next cycle has fbWe = 1, fbAddr = 1627, fbData = 5.
REQ-034 fbGrant held 0, five back-to-back plots: four accepted, plotReady = 0 on the fifth. After fbGrant rises, four in-order writes occur, then plotReady = 1.
REQ-035 Plot (160,0) and (0,120): no fbWe, dropCount = 2. 300 bad plots: dropCount = 255.
REQ-036 Two plots queued, fbGrant = 0, clearReq: plotReady = 0. After fbGrant = 1, the two plot writes precede address 0. Addresses 0..19199 are written with data 0, then clearDone pulses once and RUN resumes.
REQ-037 resetn at clear address 5000: no clearDone, fbWe = 0, dropCount = 0, plotReady = 1 the cycle after deassertion.
